// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// Holds the control FSM state enum, the supported opcodes, the datapath mux
// select encodings, the ALU operation encodings and the ImmSrc decode helper.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format selected purely from the opcode; unknown opcodes fall back to I-type.
  function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LW, OP_ITYPE: imm = IMM_I;
      OP_SW:           imm = IMM_S;
      OP_BEQ:          imm = IMM_B;
      OP_JAL:          imm = IMM_J;
      default:         imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder.
// Ports:
//   alu_op      - requested class of operation (add, sub, or derive from funct)
//   funct3      - instr[14:12]
//   op5         - instr[5], distinguishes R-type (1) from I-type ALU (0)
//   funct7b5    - instr[30]
//   alu_control - 3-bit ALU operation select
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Map the FSM's ALU request and the instruction funct fields onto an ALU operation.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has no sub form, so instr[30] only selects sub for R-type
          3'b000: begin
            if (op5 && funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, memory port and immediate extender through
// fetch/decode/execute/memory/writeback steps and waits on MemReady in the
// memory-access states.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   op, funct3, funct7b5     - instruction fields from the instruction register
//   Zero                     - ALU zero flag (branch resolution)
//   MemReady                 - memory access completes this cycle
//   ImmSrc                   - immediate format to the extender
//   ALUSrcA, ALUSrcB         - ALU operand selects
//   ALUControl               - ALU operation
//   ResultSrc, AdrSrc        - result and memory address selects
//   IRWrite, PCWrite         - instruction register / PC load strobes
//   RegWrite, MemWrite       - register-file / data-memory write strobes
//   Illegal                  - unsupported opcode seen in DECODE
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal
);

  state_t  state_r;
  state_t  state_next_s;
  alu_op_t alu_op_s;
  logic    ir_write_s;
  logic    pc_write_s;
  logic    reg_write_s;
  logic    mem_write_s;
  logic    illegal_s;

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next_s = S_FETCH;
    alu_op_s     = ALUOP_ADD;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ResultSrc    = RES_ALUOUT;
    AdrSrc       = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        // PC+4 and the fetched word are only committed once memory delivers
        ir_write_s = MemReady;
        pc_write_s = MemReady;
        if (MemReady) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target OldPC+imm while the opcode is decoded
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXECUTER;
          OP_ITYPE:     state_next_s = S_EXECUTEI;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_JAL:       state_next_s = S_JAL;
          default: begin
            illegal_s    = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_SW) begin
          state_next_s = S_MEMWRITE;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        // write request stays up until the memory accepts it
        mem_write_s = 1'b1;
        if (MemReady) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_RD2;
        alu_op_s     = ALUOP_FUNCT;
        state_next_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_IMM;
        alu_op_s     = ALUOP_FUNCT;
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BEQ: begin
        // ALUOut still holds the target computed in DECODE
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_RD2;
        alu_op_s     = ALUOP_SUB;
        pc_write_s   = Zero;
        state_next_s = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value OldPC+4
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_s   = 1'b1;
        state_next_s = S_ALUWB;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  assign ImmSrc   = imm_src_decode(op);

  // no architectural side effect may escape while reset is held
  assign IRWrite  = ir_write_s  & ~rst;
  assign PCWrite  = pc_write_s  & ~rst;
  assign RegWrite = reg_write_s & ~rst;
  assign MemWrite = mem_write_s & ~rst;
  assign Illegal  = illegal_s   & ~rst;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
// All outputs are packed into one signature per cycle and compared against
// hand-derived values: {ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
// AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal}.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       Illegal;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Illegal    (Illegal)
  );

  wire [16:0] obs_sig = {ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
                         AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal};

  function automatic logic [16:0] sig(
    input logic [1:0] imm, input logic [1:0] a, input logic [1:0] b,
    input logic [2:0] alu, input logic [1:0] res, input logic adr,
    input logic ir, input logic pc, input logic rw, input logic mw,
    input logic ill);
    return {imm, a, b, alu, res, adr, ir, pc, rw, mw, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs after changing inputs, then compare
  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    check_eq(tag, obs_sig, exp);
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b1;

    // reset: FETCH controls, every strobe gated off
    tick();
    chk("reset_c1", sig(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("reset_c2", sig(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // lw x5,8(x1)
    chk("lw_fetch",   sig(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("lw_decode",  sig(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("lw_memadr",  sig(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("lw_memread", sig(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("lw_memwb",   sig(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();

    // sw with a slow memory: MemWrite held until MemReady
    op = 7'b0100011;
    chk("sw_fetch",  sig(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("sw_decode", sig(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("sw_memadr", sig(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sw_memwrite_wait%0d", i),
          sig(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
    end
    MemReady = 1'b1;
    chk("sw_memwrite_done", sig(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    // back in FETCH with memory stalled: no IR/PC load, stay in FETCH
    MemReady = 1'b0;
    chk("fetch_stall", sig(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("fetch_stall_hold", sig(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    MemReady = 1'b1;

    // beq: PCWrite follows Zero, MemReady ignored in BEQ
    op = 7'b1100011;
    chk("beq_fetch", sig(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("beq_decode", sig(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    Zero = 1'b1;
    chk("beq_taken",     sig(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    Zero = 1'b0;
    MemReady = 1'b0;
    chk("beq_not_taken", sig(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("beq_to_fetch", sig(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    MemReady = 1'b1;

    // R-type sub, then other funct3 values while in EXECUTER
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    chk("r_fetch", sig(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    chk("r_sub", sig(2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    funct3 = 3'b110;
    chk("r_or",  sig(2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    funct3 = 3'b010;
    chk("r_slt", sig(2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    funct3 = 3'b111;
    chk("r_and", sig(2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    funct3 = 3'b001;
    chk("r_other_funct3", sig(2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("r_aluwb", sig(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();

    // addi with instr[30] set must still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    chk("i_addi", sig(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();

    // jal: PC load in JAL, then link writeback
    op = 7'b1101111; funct7b5 = 1'b0;
    chk("jal_fetch", sig(2'b11, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    chk("jal_jal",   sig(2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk("jal_aluwb", sig(2'b11, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();

    // illegal opcode: one-cycle Illegal pulse in DECODE, then FETCH
    op = 7'b1111111;
    tick();
    chk("ill_decode", sig(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("ill_fetch",  sig(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    // reset during MEMWRITE aborts the store immediately
    op = 7'b0100011;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    chk("rst_pre_memwrite", sig(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    chk("rst_in_memwrite",  sig(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    MemReady = 1'b1;
    tick();
    chk("rst_fetch_held",   sig(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    chk("rst_fetch_release", sig(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
